// File: rtl/sn_pkg.sv
// Shared types and helpers for the stochastic-number datapath blocks.
// Includes the decoder state enum and the unipolar-to-bipolar conversion.
package sn_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } sn_dec_state_e;

   localparam int unsigned WIN_LOG2_DEFAULT = 3;

   // Maps a ones count over a 2**win_log2 window onto the signed range -WINDOW..+WINDOW.
   function automatic int sn_bipolar(input int count, input int win_log2);
      return 2 * count - (1 << win_log2);
   endfunction

endpackage

// File: rtl/sn_window_counter.sv
// Window accumulator: counts valid bits and ones over a 2**WIN_LOG2 window.
// Flags win_done on the last bit and presents the final count including that bit.
module sn_window_counter
   import sn_pkg::*;
#(
   parameter int unsigned WIN_LOG2 = WIN_LOG2_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              inc,
   input  logic              sn_bit,
   output logic              win_done,
   output logic [WIN_LOG2:0] final_count
);

   localparam logic [WIN_LOG2-1:0] LAST_IDX = '1;

   logic [WIN_LOG2-1:0] bit_cnt_q, bit_cnt_d;
   logic [WIN_LOG2:0]   ones_q, ones_d;

   assign win_done    = inc && (bit_cnt_q == LAST_IDX);
   assign final_count = ones_q + {{WIN_LOG2{1'b0}}, sn_bit};

   always_comb begin
      bit_cnt_d = bit_cnt_q;
      ones_d    = ones_q;
      if (clr || win_done) begin
         bit_cnt_d = '0;
         ones_d    = '0;
      end else if (inc) begin
         bit_cnt_d = bit_cnt_q + 1'b1;
         ones_d    = final_count;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_q <= '0;
         ones_q    <= '0;
      end else begin
         bit_cnt_q <= bit_cnt_d;
         ones_q    <= ones_d;
      end
   end

endmodule

// File: rtl/sn_stream_decoder.sv
// Stochastic bitstream decoder: counts ones per window and offers results via valid/ready.
// Define SN_DEC_BIPOLAR_EN to add the signed res_bipolar output.
module sn_stream_decoder
   import sn_pkg::*;
#(
   parameter int unsigned WIN_LOG2 = WIN_LOG2_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en,
   input  logic                       sn_bit,
   input  logic                       sn_valid,
   output logic [WIN_LOG2:0]          res_count,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic                       overrun,
   input  logic                       ovr_clr,
`ifdef SN_DEC_BIPOLAR_EN
   output logic                       busy,
   output logic signed [WIN_LOG2+1:0] res_bipolar
`else
   output logic                       busy
`endif
);

   sn_dec_state_e     state_q, state_d;
   logic              busy_q, busy_d;
   logic [WIN_LOG2:0] res_count_q, res_count_d;
   logic              res_valid_q, res_valid_d;
   logic              overrun_q, overrun_d;

   logic              accum_en, win_done, handshake, ovr_set;
   logic [WIN_LOG2:0] final_count;

   // Counting only happens in ACCUM with en still high; en low clears the partial window.
   assign accum_en  = (state_q == ACCUM) && en;
   assign handshake = res_valid_q && res_ready;
   assign ovr_set   = win_done && res_valid_q && !res_ready;

   sn_window_counter #(
      .WIN_LOG2(WIN_LOG2)
   ) u_counter (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (!accum_en),
      .inc        (accum_en && sn_valid),
      .sn_bit     (sn_bit),
      .win_done   (win_done),
      .final_count(final_count)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (en)  state_d = ACCUM;
         ACCUM:   if (!en) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == ACCUM);

      res_count_d = res_count_q;
      res_valid_d = res_valid_q;
      if (win_done) begin
         res_count_d = final_count;
         res_valid_d = 1'b1;
      end else if (handshake) begin
         res_valid_d = 1'b0;
      end

      overrun_d = overrun_q;
      if (ovr_set) begin
         overrun_d = 1'b1;
      end else if (ovr_clr) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         res_count_q <= '0;
         res_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         res_count_q <= res_count_d;
         res_valid_q <= res_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign res_count = res_count_q;
   assign res_valid = res_valid_q;
   assign overrun   = overrun_q;
   assign busy      = busy_q;

`ifdef SN_DEC_BIPOLAR_EN
   localparam int BW = WIN_LOG2 + 2;

   logic signed [WIN_LOG2+1:0] res_bipolar_q, res_bipolar_d;

   always_comb begin
      res_bipolar_d = res_bipolar_q;
      if (win_done) begin
         res_bipolar_d = BW'(sn_bipolar(int'(final_count), int'(WIN_LOG2)));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_bipolar_q <= '0;
      end else begin
         res_bipolar_q <= res_bipolar_d;
      end
   end

   assign res_bipolar = res_bipolar_q;
`endif

endmodule

// File: tb/tb_sn_stream_decoder.sv
// Bench for sn_stream_decoder (WIN_LOG2=3): directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural window model.
module tb_sn_stream_decoder;

   localparam int WL = 3;
   localparam int W  = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0, sn_bit = 1'b0, sn_valid = 1'b0, res_ready = 1'b0, ovr_clr = 1'b0;
   logic [WL:0] res_count;
   logic res_valid, overrun, busy;
`ifdef SN_DEC_BIPOLAR_EN
   logic signed [WL+1:0] res_bipolar;
`endif

   int total = 0;
   int bad   = 0;

   // Behavioural model state
   bit m_busy = 0, m_rv = 0, m_ovr = 0;
   int m_bits = 0, m_ones = 0, m_res = 0, m_bip = 0;

   sn_stream_decoder #(
      .WIN_LOG2(WL)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .sn_bit     (sn_bit),
      .sn_valid   (sn_valid),
      .res_count  (res_count),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .overrun    (overrun),
      .ovr_clr    (ovr_clr),
`ifdef SN_DEC_BIPOLAR_EN
      .busy       (busy),
      .res_bipolar(res_bipolar)
`else
      .busy       (busy)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Model: a window is W accepted bits while enabled; its ones count is published.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_rv = 0; m_ovr = 0;
         m_bits = 0; m_ones = 0; m_res = 0; m_bip = 0;
      end else begin
         bit publish, take, set_ovr;
         publish = 0;
         take    = m_rv && res_ready;
         if (!m_busy) begin
            if (en) m_busy = 1;
         end else if (!en) begin
            m_busy = 0; m_bits = 0; m_ones = 0;
         end else if (sn_valid) begin
            m_bits++;
            m_ones += int'(sn_bit);
            if (m_bits == W) publish = 1;
         end
         set_ovr = publish && m_rv && !res_ready;
         if (publish) begin
            m_res = m_ones; m_bip = 2 * m_ones - W; m_rv = 1;
            m_bits = 0; m_ones = 0;
         end else if (take) begin
            m_rv = 0;
         end
         if (set_ovr) m_ovr = 1;
         else if (ovr_clr) m_ovr = 0;
      end
   end

   always @(negedge clk) begin
      chk("cyc_res_count", int'(res_count), m_res);
      chk("cyc_res_valid", int'(res_valid), int'(m_rv));
      chk("cyc_overrun", int'(overrun), int'(m_ovr));
      chk("cyc_busy", int'(busy), int'(m_busy));
`ifdef SN_DEC_BIPOLAR_EN
      chk("cyc_res_bipolar", int'(res_bipolar), m_bip);
`endif
   end

   task automatic cyc(input logic v, input logic b);
      sn_valid = v;
      sn_bit   = b;
      @(posedge clk);
      #1;
      sn_valid = 1'b0;
      sn_bit   = 1'b0;
   endtask

   task automatic send(input logic b, input int gap);
      repeat (gap) cyc(1'b0, 1'b0);
      cyc(1'b1, b);
   endtask

   task automatic consume();
      res_ready = 1'b1;
      cyc(1'b0, 1'b0);
      res_ready = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_res_count", int'(res_count), 0);
      chk("rst_res_valid", int'(res_valid), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_busy", int'(busy), 0);
      rst_n = 1'b1;

      // 1: all-ones window
      en = 1'b1;
      cyc(1'b0, 1'b0);
      chk("t1_busy", int'(busy), 1);
      for (int i = 0; i < W; i++) send(1'b1, 0);
      chk("t1_count", int'(res_count), 8);
      chk("t1_valid", int'(res_valid), 1);
`ifdef SN_DEC_BIPOLAR_EN
      chk("t1_bipolar", int'(res_bipolar), 8);
`endif
      consume();
      chk("t1_consumed", int'(res_valid), 0);

      // 2: alternating pattern with gaps, then all zeros
      for (int i = 0; i < W; i++) send(((i % 2) == 0), int'($urandom_range(0, 3)));
      chk("t2_count_alt", int'(res_count), 4);
`ifdef SN_DEC_BIPOLAR_EN
      chk("t2_bipolar_alt", int'(res_bipolar), 0);
`endif
      consume();
      for (int i = 0; i < W; i++) send(1'b0, 0);
      chk("t2_count_zero", int'(res_count), 0);
`ifdef SN_DEC_BIPOLAR_EN
      chk("t2_bipolar_zero", int'(res_bipolar), -8);
`endif
      consume();

      // 3: overrun across two unconsumed windows, then clear
      for (int i = 0; i < W; i++) send((i < 3), 0);
      for (int i = 0; i < W; i++) send((i < 5), 0);
      chk("t3_count", int'(res_count), 5);
      chk("t3_overrun", int'(overrun), 1);
      ovr_clr = 1'b1;
      cyc(1'b0, 1'b0);
      ovr_clr = 1'b0;
      chk("t3_ovr_clr", int'(overrun), 0);
      chk("t3_still_valid", int'(res_valid), 1);
      consume();

      // 4: handshake on the load cycle of the second window
      for (int i = 0; i < W; i++) send((i < 2), 0);
      for (int i = 0; i < W - 1; i++) send((i < 6), 0);
      res_ready = 1'b1;
      send(1'b0, 0);
      res_ready = 1'b0;
      chk("t4_count", int'(res_count), 6);
      chk("t4_valid", int'(res_valid), 1);
      chk("t4_no_overrun", int'(overrun), 0);
      consume();

      // 5: abort a partial window with en low
      for (int i = 0; i < 5; i++) send(1'b1, 0);
      en = 1'b0;
      cyc(1'b0, 1'b0);
      chk("t5_busy_low", int'(busy), 0);
      cyc(1'b1, 1'b1);
      en = 1'b1;
      cyc(1'b0, 1'b0);
      chk("t5_busy_high", int'(busy), 1);
      for (int i = 0; i < W; i++) send(1'b1, 0);
      chk("t5_count", int'(res_count), 8);
      consume();

      // 6: async reset mid-window and with a pending result
      for (int i = 0; i < 3; i++) send(1'b1, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_busy_rst", int'(busy), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc(1'b0, 1'b0);
      for (int i = 0; i < W; i++) send((i < 7), 0);
      chk("t6_count", int'(res_count), 7);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_valid_rst", int'(res_valid), 0);
      chk("t6_count_rst", int'(res_count), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Random traffic
      for (int n = 0; n < 4000; n++) begin
         en        = ($urandom_range(0, 29) != 0);
         res_ready = ($urandom_range(0, 3) == 0);
         ovr_clr   = ($urandom_range(0, 15) == 0);
         sn_valid  = ($urandom_range(0, 3) != 0);
         sn_bit    = $urandom_range(0, 1) != 0;
         rst_n     = ($urandom_range(0, 499) != 0);
         @(posedge clk);
         #1;
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
